uart_rx_engine: RTL and testbench
=================================

// Module: uart_rx_engine
// PURPOSE
//  Parametrised successor UART receiver: runtime-configurable 5-8 data bits, none/even/odd parity, 1/2 stop bits.
//  Oversampled bit timing with 3-sample majority vote, input synchroniser, valid/ready holding register,
//  per-frame error flags, sticky overflow. Sits between the baud-rate generator and the RX FIFO/status register.
// PARAMETERS
//  DATA_MAX    8                        max data bits; also data_out width
//  OVERSAMPLE  16                       baud_tick pulses per bit; even, >=8
//  SAMPLE_W    $clog2(OVERSAMPLE)       sample counter width (derived)
// PORTS
//  clk             in   1         single clock
//  reset_n         in   1         asynchronous, active-low reset
//  baud_tick       in   1         1-clk pulse at OVERSAMPLE x baud rate
//  serial_data_in  in   1         async line input, idle high
//  rx_enable       in   1         0: abort any frame, hold IDLE
//  cfg_data_bits   in   2         00=5, 01=6, 10=7, 11=8 data bits
//  cfg_parity_en   in   1         1: parity bit present
//  cfg_parity_odd  in   1         1: odd parity, 0: even
//  cfg_stop2       in   1         1: two stop bits
//  rx_ready        in   1         consumer accepts data_out
//  err_clr         in   1         1-clk pulse, clears overflow_error
//  data_out        out  DATA_MAX  received data, right-justified, unused MSBs 0
//  rx_valid        out  1         holding register full
//  parity_error    out  1         frame status, qualified by rx_valid
//  stop_error      out  1         frame status, qualified by rx_valid
//  break_error     out  1         frame status, qualified by rx_valid
//  overflow_error  out  1         sticky: a frame was dropped
//  rx_busy         out  1         FSM not in IDLE
// BEHAVIOUR
//  - Reset: all outputs 0; FSM IDLE; sync flops 1; counters 0; config latch 8N1.
//  - serial_data_in passes a 2-flop synchroniser; all logic uses the synced value.
//  - States: IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK_WAIT.
//  - Sample index s advances only on baud_tick, 0..OVERSAMPLE-1, wraps 0 at each bit boundary.
//  - Bit value = majority of the synced line at s=OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1.
//    Bit decision is made at s=OVERSAMPLE/2+1.
//  - IDLE->START: baud_tick with line 0 and rx_enable=1; that tick is s=0.
//    The cfg_* inputs latch on this tick; mid-frame cfg changes are ignored.
//  - START: majority 1 -> false start, back to IDLE, no flags. Majority 0 -> DATA at bit end.
//  - DATA: LSB first, shifted right into DATA_MAX reg. After N bits -> PARITY if enabled, else STOP1.
//    Final value is reg >> (DATA_MAX-N).
//  - PARITY: even = ones(data+parity) even; odd = odd. Mismatch sets the frame parity_error.
//  - STOP1/STOP2: decide at mid-bit; a 0 sets stop_error. Do not wait for the bit end.
//    STOP1 -> STOP2 only if cfg_stop2; otherwise the frame completes at the STOP1 decision, then IDLE.
//  - Break: data all 0, parity 0 (if enabled), STOP1 0 -> break_error=1, stop_error=0, parity_error=0.
//    FSM enters BREAK_WAIT and stays until the synced line is 1, then IDLE.
//  - Frame completion:
//    holding reg empty, or rx_ready=1 in the same cycle -> load data and flags; rx_valid=1 next clk.
//    holding reg full and rx_ready=0 -> frame dropped, old data kept, overflow_error=1.
//  - Latency: rx_valid rises 1 clk after the completing baud_tick.
//  - Handshake: rx_valid & rx_ready -> rx_valid=0 next clk unless a reload happens in the same cycle.
//    data_out and flags stay stable while rx_valid=1.
//  - overflow_error clears on err_clr. If err_clr and a new overflow occur together, overflow wins.
//  - rx_enable=0: next clk FSM=IDLE, partial frame discarded, holding reg and flags untouched.
//  - baud_tick absent: FSM holds; no timeout.
// STRUCTURE
//  - uart_pkg: rx_state_e enum, data_bits_e encoding, parity helper function, default OVERSAMPLE.
//  - Sub-module uart_rx_sampler: synchroniser, sample counter, majority vote.
//    Outputs: bit_strobe, bit_val, bit_end.
//  - Top: FSM, shift reg, bit counter, config latch, holding reg/handshake.
// TESTING (OVERSAMPLE=16, one baud_tick every 4 clk)
//  - 8E1 byte 0xA5, rx_ready=1 -> data_out=0xA5, rx_valid for 1 clk, no flags.
//  - 5O2 value 0x13, odd parity bit forced wrong -> data_out=0x13, parity_error=1, stop_error=0.
//  - 7N1, stop bit driven 0, data 0x41 -> stop_error=1, break_error=0; next frame decodes normally.
//  - 8N1, line low for 20 bit times -> single frame, data 0x00, break_error=1, then BREAK_WAIT.
//    On line release, no new frame until the next falling edge.
//  - rx_ready=0, two frames 0x11 and 0x22 -> data_out stays 0x11, overflow_error=1.
//    err_clr -> overflow_error=0.
//  - Glitch low of 6 ticks in IDLE -> no rx_valid.
//    rx_enable dropped mid-DATA -> rx_busy=0 next clk, no rx_valid.
//    Async reset asserted mid-frame -> all outputs 0.

Source files
------------

// File: rtl/uart_rx_engine_pkg.sv
// Shared types and helpers for the UART receive engine.
// FSM encodings, data-width encoding, config bundle, parity check.
package uart_rx_engine_pkg;

    localparam int OVERSAMPLE_DEF = 16;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_START      = 3'd1;
    localparam logic [2:0] ST_DATA       = 3'd2;
    localparam logic [2:0] ST_PARITY     = 3'd3;
    localparam logic [2:0] ST_STOP1      = 3'd4;
    localparam logic [2:0] ST_STOP2      = 3'd5;
    localparam logic [2:0] ST_BREAK_WAIT = 3'd6;

    typedef enum logic [1:0] {
        DB_5 = 2'b00,
        DB_6 = 2'b01,
        DB_7 = 2'b10,
        DB_8 = 2'b11
    } data_bits_e;

    typedef struct packed {
        data_bits_e bits;
        logic       par_en;
        logic       par_odd;
        logic       stop2;
    } rx_cfg_t;

    localparam rx_cfg_t CFG_8N1 = '{
        bits:    DB_8,
        par_en:  1'b0,
        par_odd: 1'b0,
        stop2:   1'b0
    };

    function automatic logic [3:0] n_bits(input data_bits_e b);
        return 4'd5 + {2'b00, b};
    endfunction

    // ones_par is the XOR of the data bits
    function automatic logic parity_mismatch(
        input logic ones_par,
        input logic par_bit,
        input logic odd
    );
        return (ones_par ^ par_bit) != odd;
    endfunction

endpackage

// File: rtl/uart_rx_engine_if.sv
// Consumer-side bundle of the UART receive engine.
// Engine is master: drives data/valid/flags, receives ready/err_clr.
interface uart_rx_engine_if #(
    parameter int DATA_MAX = 8
);
    logic [DATA_MAX-1:0] data_out;
    logic                rx_valid;
    logic                rx_ready;
    logic                parity_error;
    logic                stop_error;
    logic                break_error;
    logic                overflow_error;
    logic                err_clr;

    modport master (
        output data_out,
        output rx_valid,
        output parity_error,
        output stop_error,
        output break_error,
        output overflow_error,
        input  rx_ready,
        input  err_clr
    );

    modport slave (
        input  data_out,
        input  rx_valid,
        input  parity_error,
        input  stop_error,
        input  break_error,
        input  overflow_error,
        output rx_ready,
        output err_clr
    );
endinterface

// File: rtl/uart_rx_engine_sampler.sv
// Line synchroniser, oversample counter and 3-sample majority vote.
// bit_strobe marks the mid-bit decision, bit_end the last sample.
module uart_rx_engine_sampler #(
    parameter int OVERSAMPLE = 16,
    parameter int SAMPLE_W   = $clog2(OVERSAMPLE)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic baud_tick,
    input  logic serial_data_in,
    input  logic hold,
    input  logic start,
    output logic line,
    output logic bit_strobe,
    output logic bit_val,
    output logic bit_end
);

    localparam logic [SAMPLE_W-1:0] S_LO   = SAMPLE_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SAMPLE_W-1:0] S_MID  = SAMPLE_W'(OVERSAMPLE / 2);
    localparam logic [SAMPLE_W-1:0] S_HI   = SAMPLE_W'(OVERSAMPLE / 2 + 1);
    localparam logic [SAMPLE_W-1:0] S_LAST = SAMPLE_W'(OVERSAMPLE - 1);

    logic                sync1_q, sync1_d;
    logic                sync2_q, sync2_d;
    logic [SAMPLE_W-1:0] s_q, s_d;
    logic                smp_a_q, smp_a_d;
    logic                smp_b_q, smp_b_d;

    assign line = sync2_q;

    // Next-state for synchroniser, sample index and the two early samples
    always_comb begin
        sync1_d = serial_data_in;
        sync2_d = sync1_q;
        s_d     = s_q;
        smp_a_d = smp_a_q;
        smp_b_d = smp_b_q;
        // start tick itself is sample 0, so the next index is 1
        if (start) begin
            s_d = SAMPLE_W'(1);
        end else if (hold) begin
            s_d = '0;
        end else if (baud_tick) begin
            s_d = (s_q == S_LAST) ? '0 : s_q + SAMPLE_W'(1);
        end
        if (baud_tick && !hold && s_q == S_LO) smp_a_d = line;
        if (baud_tick && !hold && s_q == S_MID) smp_b_d = line;
    end

    // State registers; line idles high out of reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            s_q     <= '0;
            smp_a_q <= 1'b1;
            smp_b_q <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            s_q     <= s_d;
            smp_a_q <= smp_a_d;
            smp_b_q <= smp_b_d;
        end
    end

    assign bit_strobe = baud_tick && !hold && (s_q == S_HI);
    assign bit_end    = baud_tick && !hold && (s_q == S_LAST);
    assign bit_val    = (smp_a_q & smp_b_q) | (smp_a_q & line) | (smp_b_q & line);

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: frame FSM, shift register, config latch,
// holding register with valid/ready handshake and error flags.
module uart_rx_engine
    import uart_rx_engine_pkg::*;
#(
    parameter int DATA_MAX   = 8,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int SAMPLE_W   = $clog2(OVERSAMPLE)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    baud_tick,
    input  logic                    serial_data_in,
    input  logic                    rx_enable,
    input  logic [1:0]              cfg_data_bits,
    input  logic                    cfg_parity_en,
    input  logic                    cfg_parity_odd,
    input  logic                    cfg_stop2,
    uart_rx_engine_if.master        rx_if,
    output logic                    rx_busy
);

    localparam int SH_W = $clog2(DATA_MAX + 1);

    logic line, bit_strobe, bit_val, bit_end;
    logic start, hold;

    logic [2:0]          state_q, state_d;
    rx_cfg_t             cfg_q, cfg_d;
    logic [DATA_MAX-1:0] sh_q, sh_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                par_bit_q, par_bit_d;
    logic                par_err_q, par_err_d;
    logic                stop_err_q, stop_err_d;

    logic [DATA_MAX-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic                perr_q, perr_d;
    logic                serr_q, serr_d;
    logic                berr_q, berr_d;
    logic                ovf_q, ovf_d;

    logic                complete, brk, fr_serr;
    logic                load, drop;
    logic [3:0]          n;
    logic [SH_W-1:0]     shamt;
    logic [DATA_MAX-1:0] data_val;

    assign start = (state_q == ST_IDLE) && baud_tick && !line && rx_enable;
    assign hold  = !rx_enable || (state_q == ST_IDLE) || (state_q == ST_BREAK_WAIT);

    uart_rx_engine_sampler #(
        .OVERSAMPLE (OVERSAMPLE),
        .SAMPLE_W   (SAMPLE_W)
    ) u_sampler (
        .clk            (clk),
        .reset_n        (reset_n),
        .baud_tick      (baud_tick),
        .serial_data_in (serial_data_in),
        .hold           (hold),
        .start          (start),
        .line           (line),
        .bit_strobe     (bit_strobe),
        .bit_val        (bit_val),
        .bit_end        (bit_end)
    );

    // bits arrive LSB first into the top, so right-justify by the unused width
    assign n        = n_bits(cfg_q.bits);
    assign shamt    = SH_W'(DATA_MAX) - SH_W'(n);
    assign data_val = sh_q >> shamt;

    // Frame FSM: bit sequencing and per-frame status
    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        sh_d       = sh_q;
        cnt_d      = cnt_q;
        par_bit_d  = par_bit_q;
        par_err_d  = par_err_q;
        stop_err_d = stop_err_q;
        complete   = 1'b0;
        brk        = 1'b0;
        fr_serr    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_START;
                    cfg_d.bits    = data_bits_e'(cfg_data_bits);
                    cfg_d.par_en  = cfg_parity_en;
                    cfg_d.par_odd = cfg_parity_odd;
                    cfg_d.stop2   = cfg_stop2;
                    sh_d          = '0;
                    cnt_d         = '0;
                    par_bit_d     = 1'b0;
                    par_err_d     = 1'b0;
                    stop_err_d    = 1'b0;
                end
            end
            ST_START: begin
                if (bit_strobe && bit_val) begin
                    state_d = ST_IDLE;
                end else if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_strobe) begin
                    sh_d  = {bit_val, sh_q[DATA_MAX-1:1]};
                    cnt_d = cnt_q + 4'd1;
                end
                if (bit_end && cnt_q == n) begin
                    state_d = cfg_q.par_en ? ST_PARITY : ST_STOP1;
                end
            end
            ST_PARITY: begin
                if (bit_strobe) begin
                    par_bit_d = bit_val;
                    par_err_d = parity_mismatch(^data_val, bit_val, cfg_q.par_odd);
                end
                if (bit_end) state_d = ST_STOP1;
            end
            ST_STOP1: begin
                if (bit_strobe) begin
                    if (!bit_val && sh_q == '0 && !par_bit_q) begin
                        brk      = 1'b1;
                        complete = 1'b1;
                        state_d  = ST_BREAK_WAIT;
                    end else if (cfg_q.stop2) begin
                        stop_err_d = !bit_val;
                        state_d    = ST_STOP2;
                    end else begin
                        complete = 1'b1;
                        fr_serr  = !bit_val;
                        state_d  = ST_IDLE;
                    end
                end
            end
            ST_STOP2: begin
                if (bit_strobe) begin
                    complete = 1'b1;
                    fr_serr  = stop_err_q | !bit_val;
                    state_d  = ST_IDLE;
                end
            end
            ST_BREAK_WAIT: begin
                if (line) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!rx_enable) begin
            state_d  = ST_IDLE;
            complete = 1'b0;
            brk      = 1'b0;
        end
    end

    assign load = complete && (!valid_q || rx_if.rx_ready);
    assign drop = complete && valid_q && !rx_if.rx_ready;

    // Holding register, handshake and sticky overflow
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        serr_d  = serr_q;
        berr_d  = berr_q;
        ovf_d   = ovf_q;
        if (load) begin
            data_d  = data_val;
            valid_d = 1'b1;
            perr_d  = brk ? 1'b0 : par_err_q;
            serr_d  = brk ? 1'b0 : fr_serr;
            berr_d  = brk;
        end else if (valid_q && rx_if.rx_ready) begin
            valid_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end else if (rx_if.err_clr) begin
            ovf_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cfg_q      <= CFG_8N1;
            sh_q       <= '0;
            cnt_q      <= '0;
            par_bit_q  <= 1'b0;
            par_err_q  <= 1'b0;
            stop_err_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
            berr_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            par_bit_q  <= par_bit_d;
            par_err_q  <= par_err_d;
            stop_err_q <= stop_err_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            serr_q     <= serr_d;
            berr_q     <= berr_d;
            ovf_q      <= ovf_d;
        end
    end

    assign rx_if.data_out       = data_q;
    assign rx_if.rx_valid       = valid_q;
    assign rx_if.parity_error   = perr_q;
    assign rx_if.stop_error     = serr_q;
    assign rx_if.break_error    = berr_q;
    assign rx_if.overflow_error = ovf_q;
    assign rx_busy              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for the UART receive engine.
// 16x oversampling, one baud_tick every 4 clocks, 64 clocks per bit.
module tb_uart_rx_engine;

    localparam int BIT_CLK = 64;

    logic       clk;
    logic       reset_n;
    logic       baud_tick;
    logic       serial_data_in;
    logic       rx_enable;
    logic [1:0] cfg_data_bits;
    logic       cfg_parity_en;
    logic       cfg_parity_odd;
    logic       cfg_stop2;
    logic       rx_busy;

    uart_rx_engine_if #(.DATA_MAX(8)) rx_if ();

    uart_rx_engine #(
        .DATA_MAX   (8),
        .OVERSAMPLE (16)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .baud_tick      (baud_tick),
        .serial_data_in (serial_data_in),
        .rx_enable      (rx_enable),
        .cfg_data_bits  (cfg_data_bits),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_stop2      (cfg_stop2),
        .rx_if          (rx_if),
        .rx_busy        (rx_busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    int   tick_cnt = 0;
    int   rises    = 0;
    int   hi_cyc   = 0;
    logic prev_v   = 1'b0;
    logic [7:0] cap_data = '0;
    logic cap_p = 1'b0;
    logic cap_s = 1'b0;
    logic cap_b = 1'b0;
    int   r0;
    int   h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one-clock baud_tick every fourth clock
    always @(negedge clk) begin
        tick_cnt  = (tick_cnt + 1) % 4;
        baud_tick = (tick_cnt == 0);
    end

    // capture each new holding-register load
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_v = 1'b0;
        end else begin
            if (rx_if.rx_valid && !prev_v) begin
                rises++;
                cap_data = rx_if.data_out;
                cap_p    = rx_if.parity_error;
                cap_s    = rx_if.stop_error;
                cap_b    = rx_if.break_error;
            end
            if (rx_if.rx_valid) hi_cyc++;
            prev_v = rx_if.rx_valid;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input int nclk);
        serial_data_in = v;
        repeat (nclk) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input int nb, input logic pen,
                        input logic podd, input logic pflip,
                        input logic s2, input logic stop_v);
        logic [7:0] m;
        logic       p;
        m = d & 8'((1 << nb) - 1);
        p = (^m) ^ podd ^ pflip;
        drive_bit(1'b0, BIT_CLK);
        for (int i = 0; i < nb; i++) drive_bit(m[i], BIT_CLK);
        if (pen) drive_bit(p, BIT_CLK);
        drive_bit(stop_v, BIT_CLK);
        if (s2) drive_bit(1'b1, BIT_CLK);
        drive_bit(1'b1, 2 * BIT_CLK);
    endtask

    initial begin
        reset_n         = 1'b0;
        serial_data_in  = 1'b1;
        rx_enable       = 1'b1;
        cfg_data_bits   = 2'b11;
        cfg_parity_en   = 1'b0;
        cfg_parity_odd  = 1'b0;
        cfg_stop2       = 1'b0;
        rx_if.rx_ready  = 1'b1;
        rx_if.err_clr   = 1'b0;
        repeat (5) @(negedge clk);

        check("rst_valid", 32'(rx_if.rx_valid), 0);
        check("rst_data", 32'(rx_if.data_out), 0);
        check("rst_perr", 32'(rx_if.parity_error), 0);
        check("rst_serr", 32'(rx_if.stop_error), 0);
        check("rst_berr", 32'(rx_if.break_error), 0);
        check("rst_ovf", 32'(rx_if.overflow_error), 0);
        check("rst_busy", 32'(rx_busy), 0);

        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        // 8E1 0xA5, consumer always ready
        cfg_data_bits = 2'b11; cfg_parity_en = 1'b1;
        cfg_parity_odd = 1'b0; cfg_stop2 = 1'b0;
        r0 = rises; h0 = hi_cyc;
        send(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("8e1_count", 32'(rises - r0), 1);
        check("8e1_width", 32'(hi_cyc - h0), 1);
        check("8e1_data", 32'(cap_data), 32'hA5);
        check("8e1_perr", 32'(cap_p), 0);
        check("8e1_serr", 32'(cap_s), 0);
        check("8e1_berr", 32'(cap_b), 0);

        // 5O2 0x13 with wrong parity bit
        cfg_data_bits = 2'b00; cfg_parity_en = 1'b1;
        cfg_parity_odd = 1'b1; cfg_stop2 = 1'b1;
        r0 = rises;
        send(8'h13, 5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check("5o2_count", 32'(rises - r0), 1);
        check("5o2_data", 32'(cap_data), 32'h13);
        check("5o2_perr", 32'(cap_p), 1);
        check("5o2_serr", 32'(cap_s), 0);

        // 7N1 0x41 with stop bit low, then a clean 0x2A
        cfg_data_bits = 2'b10; cfg_parity_en = 1'b0;
        cfg_parity_odd = 1'b0; cfg_stop2 = 1'b0;
        r0 = rises;
        send(8'h41, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("7n1_count", 32'(rises - r0), 1);
        check("7n1_data", 32'(cap_data), 32'h41);
        check("7n1_serr", 32'(cap_s), 1);
        check("7n1_berr", 32'(cap_b), 0);
        send(8'h2A, 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("7n1b_count", 32'(rises - r0), 2);
        check("7n1b_data", 32'(cap_data), 32'h2A);
        check("7n1b_serr", 32'(cap_s), 0);

        // 8N1 line low for 20 bit times
        cfg_data_bits = 2'b11;
        r0 = rises;
        drive_bit(1'b0, 20 * BIT_CLK);
        check("brk_busy", 32'(rx_busy), 1);
        check("brk_count", 32'(rises - r0), 1);
        check("brk_data", 32'(cap_data), 0);
        check("brk_berr", 32'(cap_b), 1);
        check("brk_serr", 32'(cap_s), 0);
        check("brk_perr", 32'(cap_p), 0);
        drive_bit(1'b1, 4 * BIT_CLK);
        check("brk_idle", 32'(rx_busy), 0);
        check("brk_nonew", 32'(rises - r0), 1);

        // overflow with consumer stalled
        rx_if.rx_ready = 1'b0;
        send(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ovf_valid1", 32'(rx_if.rx_valid), 1);
        check("ovf_data1", 32'(rx_if.data_out), 32'h11);
        check("ovf_flag1", 32'(rx_if.overflow_error), 0);
        send(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ovf_valid2", 32'(rx_if.rx_valid), 1);
        check("ovf_data2", 32'(rx_if.data_out), 32'h11);
        check("ovf_flag2", 32'(rx_if.overflow_error), 1);
        rx_if.err_clr = 1'b1;
        @(negedge clk);
        rx_if.err_clr = 1'b0;
        check("ovf_clr", 32'(rx_if.overflow_error), 0);
        rx_if.rx_ready = 1'b1;
        @(negedge clk);
        check("ovf_drain", 32'(rx_if.rx_valid), 0);

        // short low glitch in IDLE
        r0 = rises;
        drive_bit(1'b0, 24);
        drive_bit(1'b1, 4 * BIT_CLK);
        check("glitch_count", 32'(rises - r0), 0);
        check("glitch_busy", 32'(rx_busy), 0);

        // rx_enable dropped in the middle of the data bits
        r0 = rises;
        drive_bit(1'b0, BIT_CLK);
        drive_bit(1'b1, BIT_CLK);
        drive_bit(1'b0, BIT_CLK);
        drive_bit(1'b1, BIT_CLK);
        check("en_busy_pre", 32'(rx_busy), 1);
        rx_enable = 1'b0;
        @(posedge clk);
        #1;
        check("en_busy_post", 32'(rx_busy), 0);
        drive_bit(1'b1, 8 * BIT_CLK);
        rx_enable = 1'b1;
        drive_bit(1'b1, 2 * BIT_CLK);
        check("en_count", 32'(rises - r0), 0);

        // async reset in the middle of a frame
        rx_if.rx_ready = 1'b0;
        send(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ar_valid_pre", 32'(rx_if.rx_valid), 1);
        drive_bit(1'b0, BIT_CLK);
        drive_bit(1'b1, 100);
        check("ar_busy_pre", 32'(rx_busy), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_valid", 32'(rx_if.rx_valid), 0);
        check("ar_data", 32'(rx_if.data_out), 0);
        check("ar_perr", 32'(rx_if.parity_error), 0);
        check("ar_serr", 32'(rx_if.stop_error), 0);
        check("ar_berr", 32'(rx_if.break_error), 0);
        check("ar_ovf", 32'(rx_if.overflow_error), 0);
        check("ar_busy", 32'(rx_busy), 0);
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
